// File: rtl/mux_arbiter.sv
// mux_arbiter: two-port packet arbiter that steers one port at a time onto a
// shared downstream link. A packet opens with a HEAD flit and closes with a
// TAIL flit. The mux stays locked to the winning port until that port's TAIL
// transfers. When both ports request at once, a round-robin pointer breaks
// the tie.
//
// Optional feature: define MUX_ARB_TIMEOUT_EN to enable the stall watchdog.
// The watchdog forces a lock release after TIMEOUT cycles without a transfer.
//
// Handshake: a flit on port x transfers in any cycle where the mux is locked
// to x, ivalid_x is 1 and iready is 1. That transfer cycle is flagged by
// grant_x. A source keeps its flit and its valid asserted until granted.
//
// Parameter:
//   TIMEOUT    stall cycles before a forced release (2..31)
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_       synchronous active-low reset
//   ivalid_0   port-0 flit valid
//   itype_0    port-0 flit type (00 NONE, 01 HEAD, 10 DATA, 11 TAIL)
//   ivalid_1   port-1 flit valid
//   itype_1    port-1 flit type
//   iready     downstream accepts a flit this cycle
//   sel        registered one-hot select (01 port 0, 10 port 1, 00 none)
//   grant_0    port-0 flit transfers this cycle
//   grant_1    port-1 flit transfers this cycle
//   lock       a packet currently holds the mux
//   timeout    one-cycle pulse on a forced lock release
//   state_dbg  current FSM state (00 IDLE, 01 LOCK0, 10 LOCK1)
module mux_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       ivalid_0,
  input  logic [1:0] itype_0,
  input  logic       ivalid_1,
  input  logic [1:0] itype_1,
  input  logic       iready,
  output logic [1:0] sel,
  output logic       grant_0,
  output logic       grant_1,
  output logic       lock,
  output logic       timeout,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b11;

  // The state encoding matches the sel encoding, so sel is loaded with next_state.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t     state, next_state;
  logic [1:0] sel_q;
  logic       ptr, next_ptr;   // last port granted a full packet
  logic       req_0, req_1;
  logic       xfer, tail_xfer;
  logic       stall_expired;

  assign req_0     = ivalid_0 && (itype_0 == TYPE_HEAD);
  assign req_1     = ivalid_1 && (itype_1 == TYPE_HEAD);
  assign xfer      = grant_0 || grant_1;
  assign tail_xfer = (grant_0 && (itype_0 == TYPE_TAIL)) ||
                     (grant_1 && (itype_1 == TYPE_TAIL));

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [4:0] STALL_LIMIT = 5'(TIMEOUT - 1);

  logic [4:0] stall_cnt;
  logic       timeout_q;

  // The count stays 0 in IDLE, so a new lock always starts from 0.
  assign stall_expired = (state != IDLE) && !xfer && (stall_cnt == STALL_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_) begin
      stall_cnt <= 5'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= stall_expired;
      if (state == IDLE || xfer || stall_expired) begin
        stall_cnt <= 5'd0;
      end else begin
        stall_cnt <= stall_cnt + 5'd1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign stall_expired = 1'b0;
  assign timeout       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= IDLE;
      sel_q <= 2'b00;
      ptr   <= 1'b1;
    end else begin
      state <= next_state;
      sel_q <= next_state;
      ptr   <= next_ptr;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        if (req_0 && req_1) begin
          next_state = ptr ? LOCK0 : LOCK1;
        end else if (req_0) begin
          next_state = LOCK0;
        end else if (req_1) begin
          next_state = LOCK1;
        end
      end
      LOCK0: begin
        if (tail_xfer || stall_expired) begin
          next_state = IDLE;
          next_ptr   = 1'b0;
        end
      end
      LOCK1: begin
        if (tail_xfer || stall_expired) begin
          next_state = IDLE;
          next_ptr   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    grant_0 = (state == LOCK0) && ivalid_0 && iready;
    grant_1 = (state == LOCK1) && ivalid_1 && iready;
    lock    = (state != IDLE);
  end

  assign sel       = sel_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  localparam int TO = 16;
  localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       ivalid_0 = 1'b0, ivalid_1 = 1'b0, iready = 1'b0;
  logic [1:0] itype_0 = 2'b00, itype_1 = 2'b00;
  logic [1:0] sel, state_dbg;
  logic       grant_0, grant_1, lock, timeout;

  mux_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .iready(iready),
    .sel(sel), .grant_0(grant_0), .grant_1(grant_1),
    .lock(lock), .timeout(timeout), .state_dbg(state_dbg)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Flit sources: one queue of flit types per port, front flit presented
  // until granted.
  logic [1:0] q0[$], q1[$];
  logic       rst_v = 1'b0;
  logic       rdy = 1'b1;
  bit         g0n = 0, g1n = 0;

  // Scoreboard record of what the DUT did
  int gcnt0 = 0, gcnt1 = 0, tcnt = 0;
  int head_order[$];

  // Behavioural model: owner of the mux (-1 none), round-robin pointer,
  // stall count and pending timeout pulse.
  int  m_owner, m_ptr, m_stall;
  bit  m_tpulse;
  bit  m_valid = 0;

  always @(negedge clk) begin
    int e_sel;
    bit e_g0, e_g1;
    bit r0, r1;
    g0n = grant_0;
    g1n = grant_1;
    e_g0 = (m_owner == 0) && ivalid_0 && iready;
    e_g1 = (m_owner == 1) && ivalid_1 && iready;
    if (m_valid) begin
      e_sel = (m_owner == 0) ? 1 : (m_owner == 1) ? 2 : 0;
      chk("sel", int'(sel), e_sel);
      chk("lock", int'(lock), int'(m_owner >= 0));
      chk("grant_0", int'(grant_0), int'(e_g0));
      chk("grant_1", int'(grant_1), int'(e_g1));
      chk("timeout", int'(timeout), int'(m_tpulse));
      if (grant_0) gcnt0++;
      if (grant_1) gcnt1++;
      if (grant_0 && itype_0 == T_HEAD) head_order.push_back(0);
      if (grant_1 && itype_1 == T_HEAD) head_order.push_back(1);
      if (timeout) tcnt++;
    end
    // Advance the model to the state after the coming rising edge
    if (!rst_) begin
      m_owner = -1; m_ptr = 1; m_stall = 0; m_tpulse = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_tpulse = 0;
      if (m_owner < 0) begin
        r0 = ivalid_0 && itype_0 == T_HEAD;
        r1 = ivalid_1 && itype_1 == T_HEAD;
        if (r0 && r1) m_owner = (m_ptr == 0) ? 1 : 0;
        else if (r0)  m_owner = 0;
        else if (r1)  m_owner = 1;
        m_stall = 0;
      end else if ((e_g0 && itype_0 == T_TAIL) || (e_g1 && itype_1 == T_TAIL)) begin
        m_ptr = m_owner; m_owner = -1; m_stall = 0;
      end else if (e_g0 || e_g1) begin
        m_stall = 0;
      end else begin
`ifdef MUX_ARB_TIMEOUT_EN
        if (m_stall == TO - 1) begin
          m_ptr = m_owner; m_owner = -1; m_stall = 0; m_tpulse = 1;
        end else begin
          m_stall++;
        end
`endif
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    rst_ = rst_v;
    if (g0n && q0.size() > 0) void'(q0.pop_front());
    if (g1n && q1.size() > 0) void'(q1.pop_front());
    ivalid_0 = (q0.size() > 0);
    itype_0  = (q0.size() > 0) ? q0[0] : T_NONE;
    ivalid_1 = (q1.size() > 0);
    itype_1  = (q1.size() > 0) ? q1[0] : T_NONE;
    iready   = rdy;
  endtask

  task automatic push_pkt(input int port, input int ndata);
    if (port == 0) begin
      q0.push_back(T_HEAD);
      repeat (ndata) q0.push_back(T_DATA);
      q0.push_back(T_TAIL);
    end else begin
      q1.push_back(T_HEAD);
      repeat (ndata) q1.push_back(T_DATA);
      q1.push_back(T_TAIL);
    end
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && lock == 1'b0) && n < max_cyc) begin
      step();
      n++;
    end
    chk(name, int'(n < max_cyc), 1);
  endtask

  initial begin
    int gsave;
    // Reset with a pending HEAD on port 0: no grant, no lock.
    rst_v = 1'b0; rdy = 1'b1;
    q0.push_back(T_HEAD);
    repeat (3) step();
    @(negedge clk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_grant_0", int'(grant_0), 0);
    q0.delete();
    rst_v = 1'b1;
    step();

    // Tie after reset: 4 HEAD+TAIL packets alternate 0,1,0,1.
    head_order.delete();
    push_pkt(0, 0); push_pkt(1, 0);
    wait_idle("tie_a_done", 40);
    push_pkt(0, 0); push_pkt(1, 0);
    wait_idle("tie_b_done", 40);
    chk("tie_count", head_order.size(), 4);
    if (head_order.size() == 4) begin
      chk("tie_0", head_order[0], 0);
      chk("tie_1", head_order[1], 1);
      chk("tie_2", head_order[2], 0);
      chk("tie_3", head_order[3], 1);
    end

    // Single requester: port 1, HEAD + 20 DATA + TAIL.
    gcnt1 = 0;
    push_pkt(1, 20);
    step();
    @(negedge clk);
    chk("single_sel_req", int'(sel), 0);
    step();
    @(negedge clk);
    chk("single_sel_lock", int'(sel), 2);
    wait_idle("single_done", 60);
    chk("single_grants", gcnt1, 22);
    @(negedge clk);
    chk("single_sel_end", int'(sel), 0);

    // Backpressure: 5 cycles of iready=0 mid-packet.
    gcnt0 = 0;
    push_pkt(0, 8);
    repeat (4) step();
    rdy = 1'b0;
    step();
    gsave = gcnt0;
    repeat (4) step();
    @(negedge clk);
    chk("bp_sel", int'(sel), 1);
    chk("bp_lock", int'(lock), 1);
    rdy = 1'b1;
    step();
    chk("bp_no_grant", gcnt0, gsave);
    wait_idle("bp_done", 60);
    chk("bp_grants", gcnt0, 10);

    // Intrusion: port 0 HEAD arrives during a port-1 packet.
    head_order.delete();
    push_pkt(1, 6);
    repeat (3) step();
    push_pkt(0, 0);
    wait_idle("intr_done", 60);
    chk("intr_count", head_order.size(), 2);
    if (head_order.size() == 2) begin
      chk("intr_first", head_order[0], 1);
      chk("intr_second", head_order[1], 0);
    end

    // Stall on port 0 with port 1 pending.
    head_order.delete();
    tcnt = 0;
    q0.push_back(T_HEAD);
    repeat (3) step();
    push_pkt(1, 1);
`ifdef MUX_ARB_TIMEOUT_EN
    wait_idle("wd_done", 80);
    chk("wd_pulses", tcnt, 1);
`else
    repeat (25) step();
    @(negedge clk);
    chk("wd_lock_held", int'(lock), 1);
    chk("wd_sel_held", int'(sel), 1);
    step();
    chk("wd_pulses", tcnt, 0);
    q0.push_back(T_DATA);
    q0.push_back(T_TAIL);
    wait_idle("wd_done", 80);
`endif
    chk("wd_order_len", head_order.size(), 2);
    if (head_order.size() == 2) chk("wd_next_port", head_order[1], 1);

    // Reset mid-packet after 7 flits of a port-1 packet.
    gcnt1 = 0;
    push_pkt(1, 10);
    begin
      int n = 0;
      while (gcnt1 < 7 && n < 40) begin
        step();
        n++;
      end
      chk("mid_reach7", int'(n < 40), 1);
    end
    rst_v = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("mid_sel", int'(sel), 0);
    chk("mid_lock", int'(lock), 0);
    q0.delete(); q1.delete();
    rst_v = 1'b1;
    step();
    // Pointer back at port 1: port 0 wins the next tie.
    head_order.delete();
    push_pkt(0, 0); push_pkt(1, 0);
    wait_idle("mid_tie_done", 40);
    chk("mid_tie_len", head_order.size(), 2);
    if (head_order.size() == 2) chk("mid_tie_first", head_order[0], 0);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles without a transfer that a lock may stall before forced release (range 2..31).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 ivalid_0  input  1  port-0 flit valid.
REQ-005 itype_0  input  2  port-0 flit type: 00 NONE, 01 HEAD, 10 DATA, 11 TAIL.
REQ-006 ivalid_1  input  1  port-1 flit valid.
REQ-007 itype_1  input  2  port-1 flit type, same encoding.
REQ-008 iready  input  1  downstream can accept a flit this cycle.
REQ-009 sel  output  2  one-hot mux select: 01 port 0, 10 port 1, 00 none; registered.
REQ-010 grant_0 / grant_1  output  1 each  flit on that port transfers this cycle; combinational.
REQ-011 lock  output  1  high while a packet holds the mux.
REQ-012 timeout  output  1  one-cycle pulse on forced lock release.

Function
REQ-013 States are IDLE, LOCK0 and LOCK1; sel = 01 in LOCK0, 10 in LOCK1 and 00 in IDLE; lock = (state != IDLE).
REQ-014 A request is ivalid_x=1 with itype_x=HEAD, evaluated only in IDLE.
REQ-015 IDLE with one request -> LOCKx next cycle.
REQ-016 IDLE with both requests -> port != last-granted port (round-robin pointer).
REQ-017 IDLE with no request -> stay IDLE.
REQ-018 Grant latency: 1 cycle from request to sel change; the source holds its HEAD flit and valid until granted.
REQ-019 grant_x = (state == LOCKx) & ivalid_x & iready; grant of the non-locked port is always 0.
REQ-020 A transfer is any cycle with grant_x = 1.
REQ-021 Transfer of a TAIL flit -> IDLE next cycle and pointer := x.
REQ-022 A TAIL-carrying packet leaves one idle bubble cycle before the next arbitration.
REQ-023 In LOCKx, a HEAD or NONE flit from port x transfers normally and does not alter the lock.
REQ-024 Requests from the other port are ignored until the lock is released.
REQ-025 iready=0 or ivalid_x=0 in LOCKx: hold state, no grant, sel unchanged.
REQ-026 A HEAD+TAIL two-flit packet behaves like any other packet, with no special case.

Reset
REQ-027 While rst_=0 at a clock edge: state := IDLE, sel := 00, pointer := port 1 (port 0 wins the first tie), stall counter := 0, timeout := 0.
REQ-028 grant_0 and grant_1 are 0 during reset since state is IDLE.
REQ-029 Reset mid-packet abandons the lock immediately, with no tail wait.
REQ-030 The first arbitration occurs on the first edge with rst_=1.

Configuration
REQ-031 Macro MUX_ARB_TIMEOUT_EN enables the stall watchdog.
REQ-032 With MUX_ARB_TIMEOUT_EN defined, a 5-bit counter clears on each transfer or on entry to LOCK and increments each LOCK cycle without a transfer.
REQ-033 With MUX_ARB_TIMEOUT_EN defined, a count reaching TIMEOUT-1 forces IDLE next cycle, pulses timeout for 1 cycle and sets pointer := x.
REQ-034 Without MUX_ARB_TIMEOUT_EN, no counter exists, timeout is tied to 0 and the lock is held indefinitely.

Verification
REQ-035 Single requester: port 1 HEAD, 20 DATA, TAIL with iready=1 -> sel=10 one cycle after HEAD; 22 consecutive grant_1 pulses; IDLE the cycle after TAIL; sel=00.
REQ-036 Tie after reset: both HEAD at the same edge -> port 0 granted first, then port 1 after the bubble, then port 0 for the next tie (alternation over 4 packets).
REQ-037 Backpressure: iready=0 for 5 cycles mid-packet -> no grants; sel and lock stable; transfer resumes on the next iready=1 with no flit lost.
REQ-038 Intrusion: port 0 HEAD arrives while LOCK1 -> grant_0 stays 0 until port-1 TAIL, then port 0 is granted.
REQ-039 Watchdog (macro defined, TIMEOUT=16): LOCK0 with ivalid_0=0 for 16 cycles -> timeout pulses once, IDLE next, pending port 1 granted; with macro undefined, lock persists and timeout stays 0.
REQ-040 Reset mid-packet: rst_=0 in LOCK1 after 7 flits -> IDLE, sel=00, pointer=port 1 at next edge.
